// File: rtl/mac_array_ctrl_if.sv
// Control/status bundle between the MAC array sequencer and its surroundings.
// slave: sequencer side; master: the side that issues tiles and owns the SRAM/L0/array.
interface mac_array_ctrl_if #(
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
);
  logic               start;
  logic [len_bw-1:0]  cfg_len;
  logic [addr_bw-1:0] cfg_act_base;
  logic               out_valid;
  logic               sram_cen;
  logic [addr_bw-1:0] sram_addr;
  logic               l0_wr;
  logic               l0_rd;
  logic [1:0]         inst_w;
  logic               busy;
  logic               done;

  modport master (
    output start, cfg_len, cfg_act_base, out_valid,
    input  sram_cen, sram_addr, l0_wr, l0_rd, inst_w, busy, done
  );

  modport slave (
    input  start, cfg_len, cfg_act_base, out_valid,
    output sram_cen, sram_addr, l0_wr, l0_rd, inst_w, busy, done
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the MAC array: kernel load, settle gap, execute, drain, done pulse.
// SRAM read at t gives l0_wr at t+1, l0_rd at t+2, inst_w at t+3; no backpressure, out_valid only counted.
module mac_array_ctrl #(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8,
  parameter int kgap    = 8
) (
  input  logic             clk,
  input  logic             reset,
  mac_array_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KLOAD = 3'd1,
    KGAP  = 3'd2,
    EXEC  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int maxc = (col > kgap) ? col : kgap;
  localparam int cw   = $clog2(maxc + (1 << len_bw) + 1);

  if (col < 1 || kgap < 1 || row < 1) begin : g_bad_param
    $error("mac_array_ctrl: col, row and kgap must be at least 1");
  end

  state_t             state;
  state_t             state_nxt;
  logic [cw-1:0]      cnt;
  logic [cw-1:0]      cnt_nxt;
  logic [cw-1:0]      cnt_inc;
  logic [len_bw-1:0]  len_q;
  logic [len_bw-1:0]  len_nxt;
  logic [len_bw-1:0]  out_cnt;
  logic [addr_bw-1:0] base_q;
  logic [addr_bw-1:0] base_nxt;
  logic [addr_bw-1:0] addr_nxt;
  logic               cen_nxt;
  logic               kind_nxt;
  logic               out_cnt_clr;
  logic               out_cnt_en;
  logic               busy_nxt;
  logic               done_nxt;
  // Issue-kind tag travelling alongside each stage: 0 = kernel load, 1 = execute.
  logic               iss_kind;
  logic               wr_kind;
  logic               rd_kind;

  assign cnt_inc = cnt + cw'(1);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    len_nxt     = len_q;
    base_nxt    = base_q;
    cen_nxt     = 1'b1;
    addr_nxt    = '0;
    kind_nxt    = 1'b0;
    out_cnt_clr = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt   = KLOAD;
          cnt_nxt     = '0;
          len_nxt     = bus.cfg_len;
          base_nxt    = bus.cfg_act_base;
          out_cnt_clr = 1'b1;
          cen_nxt     = 1'b0;
        end
      end
      KLOAD: begin
        if (cnt == cw'(col - 1)) begin
          state_nxt = KGAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt  = cnt_inc;
          cen_nxt  = 1'b0;
          addr_nxt = addr_bw'(cnt_inc);
        end
      end
      KGAP: begin
        if (cnt == cw'(kgap - 1)) begin
          cnt_nxt = '0;
          if (len_q == '0) begin
            state_nxt = DRAIN;
          end else begin
            state_nxt = EXEC;
            cen_nxt   = 1'b0;
            addr_nxt  = base_q;
            kind_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      EXEC: begin
        if (cnt_inc == cw'(len_q)) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt  = cnt_inc;
          cen_nxt  = 1'b0;
          addr_nxt = base_q + addr_bw'(cnt_inc);
          kind_nxt = 1'b1;
        end
      end
      DRAIN: begin
        if (out_cnt == len_q) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt == KLOAD) || (state_nxt == KGAP) ||
               (state_nxt == EXEC)  || (state_nxt == DRAIN);
    done_nxt = (state_nxt == DONE);
  end

  // Results only arrive once activations are streaming; pulses past cfg_len are dropped.
  assign out_cnt_en = ((state == EXEC) || (state == DRAIN)) && bus.out_valid &&
                      (out_cnt != len_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      len_q         <= '0;
      base_q        <= '0;
      out_cnt       <= '0;
      bus.sram_cen  <= 1'b1;
      bus.sram_addr <= '0;
      iss_kind      <= 1'b0;
      bus.l0_wr     <= 1'b0;
      wr_kind       <= 1'b0;
      bus.l0_rd     <= 1'b0;
      rd_kind       <= 1'b0;
      bus.inst_w    <= 2'b00;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      len_q         <= len_nxt;
      base_q        <= base_nxt;
      if (out_cnt_clr) begin
        out_cnt <= '0;
      end else if (out_cnt_en) begin
        out_cnt <= out_cnt + len_bw'(1);
      end
      bus.sram_cen  <= cen_nxt;
      bus.sram_addr <= addr_nxt;
      iss_kind      <= kind_nxt;
      bus.l0_wr     <= ~bus.sram_cen;
      wr_kind       <= iss_kind;
      bus.l0_rd     <= bus.l0_wr;
      rd_kind       <= wr_kind;
      bus.inst_w    <= bus.l0_rd ? (rd_kind ? 2'b10 : 2'b01) : 2'b00;
      bus.busy      <= busy_nxt;
      bus.done      <= done_nxt;
    end
  end

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequencer for the 2D MAC array (a stack of mac_row instances) and its L0 input buffer.
- Runs one tile: kernel-load phase, a settle gap, then an execute phase. It drives the input SRAM read port, the L0 write/read strobes and the 2-bit inst_w at the array west edge. Encoding: inst_w[1] = execute, inst_w[0] = kernel load.
- Counts output-valid pulses to detect completion, then pulses done.

Parameters:
- col, 8, array columns; number of kernel-load words.
- row, 8, array rows (informational; the L0 width is row*bw, handled outside).
- addr_bw, 11, SRAM address width.
- len_bw, 8, width of the activation-count config.
- kgap, 8, idle cycles between the last kernel read and the first activation read.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin one tile; sampled only in IDLE
- cfg_len  in  len_bw  number of activation vectors; latched at start
- cfg_act_base  in  addr_bw  SRAM address of the first activation; latched at start
- out_valid  in  1  one pulse per completed output vector (array last-column valid)
- sram_cen  out  1  SRAM chip enable, active low
- sram_addr  out  addr_bw  SRAM read address
- l0_wr  out  1  L0 write strobe
- l0_rd  out  1  L0 read strobe
- inst_w  out  2  instruction into row 0 of the array
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle completion pulse

Behaviour:
- Reset: state=IDLE, busy=0, done=0, sram_cen=1, sram_addr=0, l0_wr=0, l0_rd=0, inst_w=00, all counters=0, issue pipeline cleared.
- Reset mid-operation: same values on the next edge; no further strobes come from the aborted tile.
- FSM states: IDLE -> KLOAD -> KGAP -> EXEC -> DRAIN -> DONE -> IDLE.
- IDLE: if start=1, latch cfg_len and cfg_act_base, clear out_cnt, go to KLOAD. Otherwise outputs stay idle. start is ignored in every other state.
- KLOAD: runs exactly col cycles. Each cycle drives sram_cen=0 and sram_addr=k for k=0..col-1, and tags the issue as kind=LOAD. Then goes to KGAP.
- KGAP: runs exactly kgap cycles with sram_cen=1. If cfg_len=0, goes to DRAIN; otherwise goes to EXEC.
- EXEC: runs exactly cfg_len cycles. Each cycle drives sram_cen=0 and sram_addr=cfg_act_base+j for j=0..cfg_len-1, wrapping modulo 2^addr_bw, and tags the issue as kind=EXEC. Then goes to DRAIN.
- DRAIN: waits until out_cnt==cfg_len, then goes to DONE. If cfg_len=0, it exits on the first DRAIN cycle.
- DONE: done=1 for one cycle, busy=0 in that cycle, next state IDLE. A start present during DONE is ignored.
- Issue pipeline: each SRAM read issued in cycle t produces:
  - l0_wr=1 in cycle t+1 (SRAM read latency 1);
  - l0_rd=1 in cycle t+2;
  - inst_w in cycle t+3 (registered L0 output): 01 for LOAD, 10 for EXEC.
- The pipeline stages are registers, so the strobes keep running into KGAP and DRAIN. inst_w=00 whenever no tagged issue is at the pipeline head. inst_w=11 is never driven.
- out_cnt increments on out_valid=1 only in EXEC or DRAIN, and saturates at cfg_len. out_valid in IDLE, KLOAD, KGAP or DONE is ignored, and extra pulses beyond cfg_len are ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Nominal tile, col=8, kgap=8. start=1 at edge 0 with cfg_len=16, cfg_act_base=0x040 -> required response:
  - KLOAD sram_addr 0..7 in cycles 1..8;
  - l0_wr in cycles 2..9, l0_rd in cycles 3..10, inst_w=01 in cycles 4..11;
  - sram_cen=1 in cycles 9..16;
  - EXEC sram_addr 0x040..0x04F in cycles 17..32, inst_w=10 in cycles 20..35, inst_w=00 in cycles 12..19;
  - after 16 out_valid pulses, done pulses exactly once and busy falls.
- cfg_len=0 -> KLOAD and KGAP as above, no EXEC reads, done in the cycle after the first DRAIN cycle, inst_w never 10.
- Address wrap, cfg_act_base=0x7FE, cfg_len=4 -> sram_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Spurious events: start pulsed during EXEC and DONE, out_valid pulsed during KLOAD, and 20 out_valid pulses for cfg_len=16 -> no restart, out_cnt ends at 16, exactly one done pulse.
- reset=1 for one cycle during EXEC (j=5) -> next cycle all outputs at reset values and no further l0/inst activity. A fresh start then reproduces the nominal sequence.
- Back-to-back: start asserted in the first IDLE cycle after done -> second tile timing identical to the first, shifted.
